// File: rtl/board_uart_framer_pkg.sv
// Shared game/frame definitions for the board UART framer: geometry, header byte,
// frame length and the 3-bit FSM state encoding.
package board_uart_framer_pkg;

  localparam int BLOCK_SIZE = 4;
  localparam int NUM_TILES  = 16;
  localparam int TOTAL_SIZE = BLOCK_SIZE * NUM_TILES;
  localparam int FRAME_LEN  = NUM_TILES + 2;
  localparam int ACK_TMO    = 4;
  localparam int IDX_W      = $clog2(FRAME_LEN);
  localparam int TMO_W      = 3;

  localparam logic [7:0]       HDR_BYTE = 8'hA5;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_SEND      = 3'd2,
    ST_WAIT_ACK  = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_NEXT      = 3'd5
  } state_t;

endpackage

// File: rtl/board_uart_framer_tile_byte_mux.sv
// Selects the frame byte for a given index: header, zero-extended tile, or checksum.
module board_uart_framer_tile_byte_mux
  import board_uart_framer_pkg::*;
(
  input  logic [TOTAL_SIZE-1:0] board,
  input  logic [IDX_W-1:0]      idx,
  input  logic [7:0]            chk,
  output logic [7:0]            tx_byte
);

  // NOTE: assigning a default before any branch keeps always_comb free of latches.
  always_comb begin
    tx_byte = HDR_BYTE;
    if (idx == LAST_IDX) begin
      tx_byte = chk;
    end else if (idx != '0 && idx <= IDX_W'(NUM_TILES)) begin
      tx_byte = 8'(board[(int'(idx) - 1) * BLOCK_SIZE +: BLOCK_SIZE]);
    end
  end

endmodule

// File: rtl/board_uart_framer.sv
// Snapshots the packed board and streams it to the UART as header, 16 tile bytes and
// an XOR checksum, pacing each byte on the transmitter's busy handshake.
module board_uart_framer
  import board_uart_framer_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [TOTAL_SIZE-1:0] i_board,
  input  logic                  i_valid,
  input  logic                  i_tx_busy,
  output logic [7:0]            o_tx_data,
  output logic                  o_tx_stb,
  output logic                  o_busy,
  output logic                  o_frame_done,
  output logic [7:0]            o_drop_cnt
);

  state_t                state_q, state_d;
  logic [TOTAL_SIZE-1:0] shadow_q, work_q;
  logic                  pending_q;
  logic [IDX_W-1:0]      idx_q;
  logic [7:0]            chk_q;
  logic [7:0]            drop_q;
  logic [TMO_W-1:0]      tmo_q;
  logic [7:0]            tx_byte;
  logic                  stb;
  logic                  frame_done;
  logic                  in_flight;

  board_uart_framer_tile_byte_mux u_mux (
    .board   (work_q),
    .idx     (idx_q),
    .chk     (chk_q),
    .tx_byte (tx_byte)
  );

  assign in_flight = (state_q != ST_IDLE);

  always_comb begin
    state_d    = state_q;
    stb        = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      ST_IDLE:      if (i_valid) state_d = ST_LOAD;
      ST_LOAD:      state_d = ST_SEND;
      ST_SEND: begin
        if (!i_tx_busy) begin
          stb     = 1'b1;
          state_d = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (i_tx_busy)                            state_d = ST_WAIT_DONE;
        else if (tmo_q == TMO_W'(ACK_TMO - 1))    state_d = ST_NEXT;
      end
      ST_WAIT_DONE: if (!i_tx_busy) state_d = ST_NEXT;
      ST_NEXT: begin
        if (idx_q == LAST_IDX) begin
          frame_done = 1'b1;
          // A capture landing in this very cycle must still start the next frame.
          state_d    = (pending_q || i_valid) ? ST_LOAD : ST_IDLE;
        end else begin
          state_d = ST_SEND;
        end
      end
      default:      state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: the wide board registers are reset too, so no stale snapshot survives an abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q  <= '0;
      work_q    <= '0;
      pending_q <= 1'b0;
      idx_q     <= '0;
      chk_q     <= '0;
      drop_q    <= '0;
      tmo_q     <= '0;
    end else begin
      if (i_valid) shadow_q <= i_board;

      // LOAD consumes the pending snapshot, so an update there is not a drop.
      if (i_valid && in_flight) begin
        pending_q <= 1'b1;
        if (pending_q && state_q != ST_LOAD && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
      end else if (state_q == ST_LOAD) begin
        pending_q <= 1'b0;
      end

      if (state_q == ST_LOAD) begin
        work_q <= shadow_q;
        idx_q  <= '0;
        chk_q  <= '0;
      end

      if (stb && idx_q != '0 && idx_q != LAST_IDX) chk_q <= chk_q ^ tx_byte;

      if (state_q == ST_WAIT_ACK) tmo_q <= tmo_q + TMO_W'(1);
      else                        tmo_q <= '0;

      if (state_q == ST_NEXT && idx_q != LAST_IDX) idx_q <= idx_q + IDX_W'(1);
    end
  end

  assign o_tx_stb     = stb;
  assign o_tx_data    = (state_q == ST_SEND) ? tx_byte : 8'h00;
  assign o_busy       = in_flight;
  assign o_frame_done = frame_done;
  assign o_drop_cnt   = drop_q;

endmodule

// File: tb/tb_board_uart_framer.sv
// Randomised scoreboard bench: expected bytes are queued from a frame-level model and
// popped by a monitor each time the framer strobes a byte to the transmitter.
module tb_board_uart_framer;
  import board_uart_framer_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [63:0] i_board = '0;
  logic        i_valid = 1'b0;
  logic        tx_line = 1'b0;
  logic        hold_busy = 1'b0;
  logic        i_tx_busy;
  logic [7:0]  o_tx_data;
  logic        o_tx_stb;
  logic        o_busy;
  logic        o_frame_done;
  logic [7:0]  o_drop_cnt;

  assign i_tx_busy = tx_line | hold_busy;

  board_uart_framer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_board      (i_board),
    .i_valid      (i_valid),
    .i_tx_busy    (i_tx_busy),
    .o_tx_data    (o_tx_data),
    .o_tx_stb     (o_tx_stb),
    .o_busy       (o_busy),
    .o_frame_done (o_frame_done),
    .o_drop_cnt   (o_drop_cnt)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  exp_q[$];
  int          tx_len = 2;
  bit          m_busy = 0;
  bit          m_has_pend = 0;
  logic [63:0] m_pend = '0;
  int          m_drops = 0;
  int          frame_strobes = 0;
  int          frames_seen = 0;
  int          cyc = 0;
  int          last_stb = 0;
  bit          gap_check = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void push_frame(input logic [63:0] b);
    logic [7:0] sum;
    logic [7:0] t;
    sum = 8'h00;
    exp_q.push_back(8'hA5);
    for (int k = 0; k < 16; k++) begin
      t = 8'((b >> (4 * k)) & 64'hF);
      sum ^= t;
      exp_q.push_back(t);
    end
    exp_q.push_back(sum);
  endfunction

  // Frame-level model: idle boards start a frame, later ones replace a single pending slot.
  function automatic void model_valid(input logic [63:0] b);
    if (!m_busy) begin
      push_frame(b);
      m_busy = 1;
    end else begin
      if (m_has_pend && m_drops < 255) m_drops++;
      m_pend     = b;
      m_has_pend = 1;
    end
  endfunction

  always @(posedge clk) cyc++;

  // Transmitter model: raises busy the cycle after a strobe for tx_len cycles.
  always begin
    @(negedge clk);
    if (rst_n && o_tx_stb && tx_len > 0) begin
      @(posedge clk);
      #1 tx_line = 1'b1;
      repeat (tx_len) @(posedge clk);
      #1 tx_line = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (o_tx_stb) begin
        check("stb_while_busy", i_tx_busy, 0);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_byte: got %0h expected none (t=%0t)", o_tx_data, $time);
        end else begin
          check("tx_byte", o_tx_data, exp_q.pop_front());
        end
        if (gap_check && frame_strobes > 0) check("tmo_gap", cyc - last_stb, 6);
        last_stb = cyc;
        frame_strobes++;
      end
      if (o_frame_done) begin
        check("frame_len", frame_strobes, 18);
        check("queue_drained", exp_q.size(), 0);
        frame_strobes = 0;
        frames_seen++;
        if (m_has_pend) begin
          push_frame(m_pend);
          m_has_pend = 0;
        end else begin
          m_busy = 0;
        end
      end
    end
  end

  task automatic send_board(input logic [63:0] b);
    @(posedge clk);
    #1;
    i_board = b;
    i_valid = 1'b1;
    model_valid(b);
    @(posedge clk);
    #1 i_valid = 1'b0;
  endtask

  task automatic wait_strobes(input int n);
    int seen = 0;
    int t = 0;
    while (seen < n && t < 2000) begin
      @(negedge clk);
      if (o_tx_stb) seen++;
      t++;
    end
    if (seen < n) begin
      n_cmp++;
      n_bad++;
      $display("FAIL strobe_timeout: got %0d strobes expected %0d", seen, n);
    end
  endtask

  task automatic wait_idle(input string tag);
    int t = 0;
    while ((m_busy || exp_q.size() != 0) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 5000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_idle_timeout: %0d bytes outstanding expected 0", tag, exp_q.size());
    end
    repeat (3) @(negedge clk);
    check({tag, "_busy_low"}, o_busy, 0);
    check({tag, "_drop_cnt"}, o_drop_cnt, m_drops);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_stb"}, o_tx_stb, 0);
    check({tag, "_data"}, o_tx_data, 0);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_done"}, o_frame_done, 0);
    check({tag, "_drop"}, o_drop_cnt, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int f0;
    int s;
    int n;
    #2 rst_n = 1'b0;
    #1 check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Empty board, 3-cycle transmitter, header two cycles after the capture.
    tx_len = 3;
    @(posedge clk);
    #1;
    i_board = '0;
    i_valid = 1'b1;
    model_valid(64'h0);
    @(posedge clk);
    #1 i_valid = 1'b0;
    @(negedge clk) check("latency_load_no_stb", o_tx_stb, 0);
    @(negedge clk) check("latency_header_stb", o_tx_stb, 1);
    wait_idle("t1");
    check("t1_frames", frames_seen, 1);

    send_board(64'h21);
    wait_idle("t2");

    // Three boards in one frame: the last one wins, one drop.
    f0 = frames_seen;
    send_board(64'hB1B1_B1B1_B1B1_B1B1);
    wait_strobes(3);
    send_board(64'hB2B2_B2B2_B2B2_B2B2);
    wait_strobes(2);
    send_board(64'hB3B3_B3B3_B3B3_B3B3);
    wait_idle("t3");
    check("t3_frames", frames_seen - f0, 2);
    check("t3_drop_is_one", o_drop_cnt, 1);

    // Transmitter never acknowledges: each byte advances on the timeout.
    tx_len = 0;
    gap_check = 1;
    f0 = frames_seen;
    send_board({$urandom, $urandom});
    wait_idle("t4");
    gap_check = 0;
    check("t4_frames", frames_seen - f0, 1);

    // Transmitter busy before the header: no strobe until it drops.
    tx_len = 2;
    hold_busy = 1'b1;
    send_board({$urandom, $urandom});
    s = 0;
    repeat (10) begin
      @(negedge clk);
      if (o_tx_stb) s++;
    end
    check("t5_no_stb_while_held", s, 0);
    check("t5_header_held", o_tx_data, 8'hA5);
    hold_busy = 1'b0;
    wait_idle("t5");

    // Reset in the middle of a frame, then a clean frame afterwards.
    tx_len = 1;
    send_board({$urandom, $urandom});
    wait_strobes(7);
    #2 rst_n = 1'b0;
    #1 check_all_zero("t6_abort");
    exp_q.delete();
    m_busy = 0;
    m_has_pend = 0;
    m_drops = 0;
    frame_strobes = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    f0 = frames_seen;
    send_board({$urandom, $urandom});
    wait_idle("t6");
    check("t6_frames", frames_seen - f0, 1);

    // Random boards, transmitter speeds and mid-frame updates.
    for (int it = 0; it < 8; it++) begin
      tx_len = $urandom_range(0, 3);
      send_board({$urandom, $urandom});
      n = $urandom_range(0, 3);
      for (int j = 0; j < n; j++) begin
        wait_strobes($urandom_range(1, 4));
        send_board({$urandom, $urandom});
      end
      wait_idle("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
